// File: rtl/elixirchip_es1_spu_op_any_stat.sv
// elixirchip_es1_spu_op_any_stat
//   Window statistics for the 1-bit result of the SPU "any" op. Samples are
//   framed by s_last. At the end of each window it reports OR, AND, a
//   saturating hit count and the index of the first hit. The result then
//   passes through a LATENCY-deep output pipeline.
//
//   Ports
//     reset          async active-high reset
//     clk            clock
//     cke            clock enable; all state freezes while low
//     s_data         per-sample result from the upstream any op
//     s_valid        sample valid
//     s_last         last sample of the window (only with s_valid)
//     s_clear        drop the partial window and all in-flight results
//     m_any          OR of the window's samples
//     m_all          AND of the window's samples
//     m_count        number of 1 samples, saturating at all-ones
//     m_first_index  index of the first 1 sample, all-ones if none
//     m_valid        one cke-enabled cycle per reported window
//
//   state | meaning
//   IDLE  | window empty, the next accepted sample starts a window
//   ACCUM | window open, accumulators hold the samples seen so far
module elixirchip_es1_spu_op_any_stat #(
    parameter int    LATENCY    = 1,
    parameter int    COUNT_BITS = 8,
    parameter string DEVICE     = "RTL",
    parameter string SIMULATION = "false",
    parameter string DEBUG      = "false"
) (
    input  logic                  reset,
    input  logic                  clk,
    input  logic                  cke,
    input  logic                  s_data,
    input  logic                  s_valid,
    input  logic                  s_last,
    input  logic                  s_clear,
    output logic                  m_any,
    output logic                  m_all,
    output logic [COUNT_BITS-1:0] m_count,
    output logic [COUNT_BITS-1:0] m_first_index,
    output logic                  m_valid
);

    if (LATENCY < 1 || LATENCY > 8 || COUNT_BITS < 2 || COUNT_BITS > 32
        || DEVICE == ""
        || (SIMULATION != "true" && SIMULATION != "false")
        || (DEBUG != "true" && DEBUG != "false")) begin : g_param_err
        $error("elixirchip_es1_spu_op_any_stat: illegal parameter value");
    end

    localparam int                    RW   = 2 * COUNT_BITS + 2;
    localparam logic [COUNT_BITS-1:0] ONES = '1;
    localparam logic [COUNT_BITS-1:0] ONE  = COUNT_BITS'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic                  acc_any_q, acc_any_d;
    logic                  acc_all_q, acc_all_d;
    logic                  acc_hit_q, acc_hit_d;
    logic [COUNT_BITS-1:0] acc_cnt_q, acc_cnt_d;
    logic [COUNT_BITS-1:0] acc_idx_q, acc_idx_d;
    logic [COUNT_BITS-1:0] acc_first_q, acc_first_d;

    logic                  accept;
    logic                  emit;
    logic [RW-1:0]         result;

    logic [LATENCY-1:0]    pv_q;
    logic [RW-1:0]         pd_q [LATENCY];

    assign accept = cke & s_valid & ~s_clear;
    assign emit   = accept & s_last;

    always_comb begin
        state_d     = state_q;
        acc_any_d   = acc_any_q;
        acc_all_d   = acc_all_q;
        acc_hit_d   = acc_hit_q;
        acc_cnt_d   = acc_cnt_q;
        acc_idx_d   = acc_idx_q;
        acc_first_d = acc_first_q;
        if (cke && s_clear) begin
            state_d = IDLE;
        end else if (accept) begin
            state_d = s_last ? IDLE : ACCUM;
            if (state_q == IDLE) begin
                acc_any_d   = s_data;
                acc_all_d   = s_data;
                acc_hit_d   = s_data;
                acc_cnt_d   = s_data ? ONE : '0;
                acc_idx_d   = '0;
                acc_first_d = s_data ? '0 : ONES;
            end else begin
                // Index saturates, so a first hit beyond the range lands on all-ones.
                acc_idx_d = (acc_idx_q == ONES) ? ONES : acc_idx_q + ONE;
                acc_any_d = acc_any_q | s_data;
                acc_all_d = acc_all_q & s_data;
                acc_hit_d = acc_hit_q | s_data;
                if (s_data && acc_cnt_q != ONES) begin
                    acc_cnt_d = acc_cnt_q + ONE;
                end
                if (s_data && !acc_hit_q) begin
                    acc_first_d = acc_idx_d;
                end
            end
        end
    end

    // The emitted result includes the s_last sample itself.
    assign result = {acc_any_d, acc_all_d, acc_cnt_d, acc_first_d};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            acc_any_q   <= 1'b0;
            acc_all_q   <= 1'b0;
            acc_hit_q   <= 1'b0;
            acc_cnt_q   <= '0;
            acc_idx_q   <= '0;
            acc_first_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_any_q   <= acc_any_d;
            acc_all_q   <= acc_all_d;
            acc_hit_q   <= acc_hit_d;
            acc_cnt_q   <= acc_cnt_d;
            acc_idx_q   <= acc_idx_d;
            acc_first_q <= acc_first_d;
        end
    end

    // Data moves only alongside a valid bit, so the last stage keeps the
    // previous result between windows and across a clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pv_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pd_q[i] <= '0;
            end
        end else if (cke) begin
            if (s_clear) begin
                pv_q <= '0;
            end else begin
                pv_q[0] <= emit;
                if (emit) begin
                    pd_q[0] <= result;
                end
                for (int i = 1; i < LATENCY; i++) begin
                    pv_q[i] <= pv_q[i-1];
                    if (pv_q[i-1]) begin
                        pd_q[i] <= pd_q[i-1];
                    end
                end
            end
        end
    end

    assign m_valid = pv_q[LATENCY-1];
    assign {m_any, m_all, m_count, m_first_index} = pd_q[LATENCY-1];

endmodule

// File: tb/tb_elixirchip_es1_spu_op_any_stat.sv
module tb_elixirchip_es1_spu_op_any_stat;

    localparam int NI = 3;

    // Three instances share the input stream: (LATENCY, COUNT_BITS) = (1,8), (3,8), (2,2)
    int lat [NI] = '{1, 3, 2};
    int cbw [NI] = '{8, 8, 2};

    logic clk = 1'b0;
    logic reset, cke, s_data, s_valid, s_last, s_clear;

    logic       a_any, a_all, a_v;
    logic [7:0] a_cnt, a_fi;
    logic       b_any, b_all, b_v;
    logic [7:0] b_cnt, b_fi;
    logic       c_any, c_all, c_v;
    logic [1:0] c_cnt, c_fi;

    elixirchip_es1_spu_op_any_stat #(.LATENCY(1), .COUNT_BITS(8)) dut_a (
        .reset(reset), .clk(clk), .cke(cke), .s_data(s_data), .s_valid(s_valid),
        .s_last(s_last), .s_clear(s_clear), .m_any(a_any), .m_all(a_all),
        .m_count(a_cnt), .m_first_index(a_fi), .m_valid(a_v));

    elixirchip_es1_spu_op_any_stat #(.LATENCY(3), .COUNT_BITS(8)) dut_b (
        .reset(reset), .clk(clk), .cke(cke), .s_data(s_data), .s_valid(s_valid),
        .s_last(s_last), .s_clear(s_clear), .m_any(b_any), .m_all(b_all),
        .m_count(b_cnt), .m_first_index(b_fi), .m_valid(b_v));

    elixirchip_es1_spu_op_any_stat #(.LATENCY(2), .COUNT_BITS(2)) dut_c (
        .reset(reset), .clk(clk), .cke(cke), .s_data(s_data), .s_valid(s_valid),
        .s_last(s_last), .s_clear(s_clear), .m_any(c_any), .m_all(c_all),
        .m_count(c_cnt), .m_first_index(c_fi), .m_valid(c_v));

    always #5 clk = ~clk;

    logic got_v [NI], got_any [NI], got_all [NI];
    int   got_cnt [NI], got_fi [NI];

    always_comb begin
        got_v[0] = a_v; got_any[0] = a_any; got_all[0] = a_all;
        got_cnt[0] = int'(a_cnt); got_fi[0] = int'(a_fi);
        got_v[1] = b_v; got_any[1] = b_any; got_all[1] = b_all;
        got_cnt[1] = int'(b_cnt); got_fi[1] = int'(b_fi);
        got_v[2] = c_v; got_any[2] = c_any; got_all[2] = c_all;
        got_cnt[2] = int'(c_cnt); got_fi[2] = int'(c_fi);
    end

    // Reference model: the open window is a list of samples; a finished
    // window becomes a result that surfaces LATENCY enabled edges later.
    typedef struct {
        int inst;
        int rem;
        bit any;
        bit all;
        int cnt;
        int fi;
    } res_t;

    bit   win_q [$];
    res_t pq [$];
    bit   exp_v [NI], exp_any [NI], exp_all [NI];
    int   exp_cnt [NI], exp_fi [NI];

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    function automatic res_t window_stats(int k);
        res_t r;
        int ones = (1 << cbw[k]) - 1;
        int n1 = 0;
        int fi = -1;
        foreach (win_q[i]) begin
            if (win_q[i]) begin
                n1++;
                if (fi < 0) fi = i;
            end
        end
        r.inst = k;
        r.rem  = lat[k];
        r.any  = (n1 > 0);
        r.all  = (n1 == win_q.size());
        r.cnt  = (n1 > ones) ? ones : n1;
        r.fi   = (fi < 0 || fi > ones) ? ones : fi;
        return r;
    endfunction

    task automatic model_edge();
        if (!cke) return;
        if (s_clear) begin
            win_q.delete();
            pq.delete();
            for (int k = 0; k < NI; k++) exp_v[k] = 1'b0;
            return;
        end
        if (s_valid) begin
            win_q.push_back(s_data);
            if (s_last) begin
                for (int k = 0; k < NI; k++) pq.push_back(window_stats(k));
                win_q.delete();
            end
        end
        for (int k = 0; k < NI; k++) exp_v[k] = 1'b0;
        for (int i = pq.size() - 1; i >= 0; i--) begin
            pq[i].rem = pq[i].rem - 1;
            if (pq[i].rem == 0) begin
                exp_v[pq[i].inst]   = 1'b1;
                exp_any[pq[i].inst] = pq[i].any;
                exp_all[pq[i].inst] = pq[i].all;
                exp_cnt[pq[i].inst] = pq[i].cnt;
                exp_fi[pq[i].inst]  = pq[i].fi;
                pq.delete(i);
            end
        end
    endtask

    task automatic model_reset();
        win_q.delete();
        pq.delete();
        for (int k = 0; k < NI; k++) begin
            exp_v[k] = 0; exp_any[k] = 0; exp_all[k] = 0; exp_cnt[k] = 0; exp_fi[k] = 0;
        end
    endtask

    task automatic tick(input bit ce, input bit v, input bit l, input bit d, input bit c);
        cke = ce; s_valid = v; s_last = l; s_data = d; s_clear = c;
        @(posedge clk);
        if (!reset) model_edge();
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        model_reset();
        for (int j = 0; j < 3; j++) begin
            tick(1, 1, j[0], 1, 0);
            for (int k = 0; k < NI; k++) begin
                n_vec++;
                if ({got_v[k], got_any[k], got_all[k]} !== 3'b000 || got_cnt[k] !== 0 || got_fi[k] !== 0) begin
                    n_err++;
                    $display("FAIL reset inst%0d cyc%0d: got v%b a%b l%b c%0d f%0d want all zero",
                             k, cyc, got_v[k], got_any[k], got_all[k], got_cnt[k], got_fi[k]);
                end
            end
        end
        reset = 1'b0;
        tick(1, 0, 0, 0, 0);
    endtask

    task automatic test_basic();
        bit [3:0] pat = 4'b0110;
        for (int j = 0; j < 8; j++) begin
            if (j < 4) tick(1, 1, j == 3, pat[j], 0);
            else       tick(1, 0, 0, 0, 0);
            for (int k = 0; k < NI; k++) begin
                n_vec++;
                if (got_v[k] !== exp_v[k] || got_any[k] !== exp_any[k] || got_all[k] !== exp_all[k]
                    || got_cnt[k] !== exp_cnt[k] || got_fi[k] !== exp_fi[k]) begin
                    n_err++;
                    $display("FAIL basic inst%0d cyc%0d: got v%b a%b l%b c%0d f%0d want v%b a%b l%b c%0d f%0d",
                             k, cyc, got_v[k], got_any[k], got_all[k], got_cnt[k], got_fi[k],
                             exp_v[k], exp_any[k], exp_all[k], exp_cnt[k], exp_fi[k]);
                end
            end
            if (j == 3) begin
                n_vec++;
                if ({a_v, a_any, a_all, a_cnt, a_fi} !== {1'b1, 1'b1, 1'b0, 8'd2, 8'd1}) begin
                    n_err++;
                    $display("FAIL basic_lat1 cyc%0d: got v%b a%b l%b c%0d f%0d want v1 a1 l0 c2 f1",
                             cyc, a_v, a_any, a_all, a_cnt, a_fi);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        bit [4:0] pat  = 5'b00111;
        bit [4:0] last = 5'b10100;
        for (int j = 0; j < 16; j++) begin
            if (j < 5)       tick(1, 1, last[j], pat[j], 0);
            else if (j < 9)  tick(1, 1, 1, 1'($urandom_range(0, 1)), 0);
            else             tick(1, 0, 0, 0, 0);
            for (int k = 0; k < NI; k++) begin
                n_vec++;
                if (got_v[k] !== exp_v[k] || got_any[k] !== exp_any[k] || got_all[k] !== exp_all[k]
                    || got_cnt[k] !== exp_cnt[k] || got_fi[k] !== exp_fi[k]) begin
                    n_err++;
                    $display("FAIL b2b inst%0d cyc%0d: got v%b a%b l%b c%0d f%0d want v%b a%b l%b c%0d f%0d",
                             k, cyc, got_v[k], got_any[k], got_all[k], got_cnt[k], got_fi[k],
                             exp_v[k], exp_any[k], exp_all[k], exp_cnt[k], exp_fi[k]);
                end
            end
            if (j <= 6) begin
                n_vec++;
                if (b_v !== (j == 4 || j == 6)) begin
                    n_err++;
                    $display("FAIL b2b_lat3_pulse step%0d: got v%b want v%b", j, b_v, (j == 4 || j == 6));
                end
            end
            if (j == 4) begin
                n_vec++;
                if ({b_any, b_all, b_cnt, b_fi} !== {1'b1, 1'b1, 8'd3, 8'd0}) begin
                    n_err++;
                    $display("FAIL b2b_first got a%b l%b c%0d f%0d want a1 l1 c3 f0", b_any, b_all, b_cnt, b_fi);
                end
            end
            if (j == 6) begin
                n_vec++;
                if ({b_any, b_all, b_cnt, b_fi} !== {1'b0, 1'b0, 8'd0, 8'hFF}) begin
                    n_err++;
                    $display("FAIL b2b_second got a%b l%b c%0d f%0d want a0 l0 c0 f255", b_any, b_all, b_cnt, b_fi);
                end
            end
        end
    endtask

    task automatic test_saturate();
        for (int j = 0; j < 16; j++) begin
            if (j < 6)       tick(1, 1, j == 5, 1, 0);
            else if (j < 12) tick(1, 1, j == 11, j == 11, 0);
            else             tick(1, 0, 0, 0, 0);
            for (int k = 0; k < NI; k++) begin
                n_vec++;
                if (got_v[k] !== exp_v[k] || got_any[k] !== exp_any[k] || got_all[k] !== exp_all[k]
                    || got_cnt[k] !== exp_cnt[k] || got_fi[k] !== exp_fi[k]) begin
                    n_err++;
                    $display("FAIL sat inst%0d cyc%0d: got v%b a%b l%b c%0d f%0d want v%b a%b l%b c%0d f%0d",
                             k, cyc, got_v[k], got_any[k], got_all[k], got_cnt[k], got_fi[k],
                             exp_v[k], exp_any[k], exp_all[k], exp_cnt[k], exp_fi[k]);
                end
            end
            if (j == 6) begin
                n_vec++;
                if ({c_v, c_cnt, c_fi} !== {1'b1, 2'd3, 2'd0}) begin
                    n_err++;
                    $display("FAIL sat_count got v%b c%0d f%0d want v1 c3 f0", c_v, c_cnt, c_fi);
                end
            end
            if (j == 12) begin
                n_vec++;
                if ({c_v, c_any, c_all, c_cnt, c_fi} !== {1'b1, 1'b1, 1'b0, 2'd1, 2'd3}) begin
                    n_err++;
                    $display("FAIL sat_index got v%b a%b l%b c%0d f%0d want v1 a1 l0 c1 f3",
                             c_v, c_any, c_all, c_cnt, c_fi);
                end
            end
        end
    endtask

    task automatic test_clear();
        int a_pulses = 0;
        int b_pulses = 0;
        for (int j = 0; j < 16; j++) begin
            case (j)
                0:       tick(1, 1, 0, 1, 0);
                1:       tick(1, 1, 0, 0, 0);
                2:       tick(1, 1, 1, 1, 1);
                3:       tick(1, 1, 1, 0, 0);
                9:       tick(1, 1, 1, 1, 0);
                10:      tick(1, 0, 0, 0, 1);
                default: tick(1, 0, 0, 0, 0);
            endcase
            a_pulses += int'(a_v);
            b_pulses += int'(b_v);
            for (int k = 0; k < NI; k++) begin
                n_vec++;
                if (got_v[k] !== exp_v[k] || got_any[k] !== exp_any[k] || got_all[k] !== exp_all[k]
                    || got_cnt[k] !== exp_cnt[k] || got_fi[k] !== exp_fi[k]) begin
                    n_err++;
                    $display("FAIL clear inst%0d cyc%0d: got v%b a%b l%b c%0d f%0d want v%b a%b l%b c%0d f%0d",
                             k, cyc, got_v[k], got_any[k], got_all[k], got_cnt[k], got_fi[k],
                             exp_v[k], exp_any[k], exp_all[k], exp_cnt[k], exp_fi[k]);
                end
            end
        end
        n_vec++;
        if (a_pulses !== 2 || b_pulses !== 1) begin
            n_err++;
            $display("FAIL clear_pulses got lat1=%0d lat3=%0d want lat1=2 lat3=1", a_pulses, b_pulses);
        end
        n_vec++;
        if ({b_any, b_cnt, b_fi} !== {1'b0, 8'd0, 8'hFF}) begin
            n_err++;
            $display("FAIL clear_hold got a%b c%0d f%0d want a0 c0 f255", b_any, b_cnt, b_fi);
        end
    endtask

    task automatic test_stall_reset();
        for (int j = 0; j < 20; j++) begin
            if (j < 2)                 tick(1, 1, 0, 1, 0);
            else if (j < 7)            tick(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            else if (j == 7)           tick(1, 1, 1, 0, 0);
            else if (j < 13)           tick(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            else                       tick(1, 0, 0, 0, 0);
            for (int k = 0; k < NI; k++) begin
                n_vec++;
                if (got_v[k] !== exp_v[k] || got_any[k] !== exp_any[k] || got_all[k] !== exp_all[k]
                    || got_cnt[k] !== exp_cnt[k] || got_fi[k] !== exp_fi[k]) begin
                    n_err++;
                    $display("FAIL stall inst%0d cyc%0d: got v%b a%b l%b c%0d f%0d want v%b a%b l%b c%0d f%0d",
                             k, cyc, got_v[k], got_any[k], got_all[k], got_cnt[k], got_fi[k],
                             exp_v[k], exp_any[k], exp_all[k], exp_cnt[k], exp_fi[k]);
                end
            end
            if (j >= 7 && j <= 13) begin
                n_vec++;
                if (a_v !== (j != 13)) begin
                    n_err++;
                    $display("FAIL stall_hold step%0d: got v%b want v%b", j, a_v, (j != 13));
                end
            end
        end
        tick(1, 1, 0, 1, 0);
        tick(1, 1, 1, 1, 0);
        tick(1, 1, 0, 1, 0);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        n_vec++;
        if ({a_v, a_any, a_all, a_cnt, a_fi, b_v, b_any, b_all, b_cnt, b_fi, c_v, c_any, c_all, c_cnt, c_fi} !== '0) begin
            n_err++;
            $display("FAIL async_reset got a:v%b c%0d f%0d b:v%b c%0d f%0d c:v%b c%0d f%0d want all zero",
                     a_v, a_cnt, a_fi, b_v, b_cnt, b_fi, c_v, c_cnt, c_fi);
        end
        tick(1, 1, 1, 1, 0);
        reset = 1'b0;
        for (int j = 0; j < 6; j++) begin
            tick(1, 0, 0, 0, 0);
            for (int k = 0; k < NI; k++) begin
                n_vec++;
                if (got_v[k] !== exp_v[k] || got_any[k] !== exp_any[k] || got_all[k] !== exp_all[k]
                    || got_cnt[k] !== exp_cnt[k] || got_fi[k] !== exp_fi[k]) begin
                    n_err++;
                    $display("FAIL post_reset inst%0d cyc%0d: got v%b a%b l%b c%0d f%0d want v%b a%b l%b c%0d f%0d",
                             k, cyc, got_v[k], got_any[k], got_all[k], got_cnt[k], got_fi[k],
                             exp_v[k], exp_any[k], exp_all[k], exp_cnt[k], exp_fi[k]);
                end
            end
        end
    endtask

    task automatic test_random();
        bit bias;
        for (int j = 0; j < 4000; j++) begin
            if (j % 64 == 0) bias = 1'($urandom);
            tick(($urandom % 8) != 0,
                 ($urandom % 4) != 0,
                 ($urandom % 6) == 0,
                 bias ? (($urandom % 16) != 0) : 1'($urandom),
                 ($urandom % 50) == 0);
            for (int k = 0; k < NI; k++) begin
                n_vec++;
                if (got_v[k] !== exp_v[k] || got_any[k] !== exp_any[k] || got_all[k] !== exp_all[k]
                    || got_cnt[k] !== exp_cnt[k] || got_fi[k] !== exp_fi[k]) begin
                    n_err++;
                    $display("FAIL random inst%0d cyc%0d: got v%b a%b l%b c%0d f%0d want v%b a%b l%b c%0d f%0d",
                             k, cyc, got_v[k], got_any[k], got_all[k], got_cnt[k], got_fi[k],
                             exp_v[k], exp_any[k], exp_all[k], exp_cnt[k], exp_fi[k]);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1; cke = 1'b0; s_data = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_clear = 1'b0;
        model_reset();
        test_reset();
        test_basic();
        test_back_to_back();
        test_saturate();
        test_clear();
        test_stall_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
